// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared widths, constants and entry type for the instruction queue
package instr_queue_pkg;

    localparam int   INSTR_W           = 32;
    localparam int   ADDR_W            = 32;
    localparam int   QUEUE_DEPTH_DEF   = 16;
    localparam logic TRUE              = 1'b1;
    localparam logic FALSE             = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } queue_entry_t;

    localparam int ENTRY_W = $bits(queue_entry_t);

endpackage

// File: rtl/instr_queue_ram.sv
// rtl/instr_queue_ram.sv - queue storage: one synchronous write port, one asynchronous read port
module instr_queue_ram
    import instr_queue_pkg::*;
#(
    parameter int DEPTH  = QUEUE_DEPTH_DEF,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  queue_entry_t       wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output queue_entry_t       rd_data
);

    // Contents are deliberately left unreset; the pointers decide what is valid.
    queue_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-decode instruction queue with flush and global ready
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH  = QUEUE_DEPTH_DEF,
    parameter int QUEUE_ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               update_stat,
    input  logic               fetch_valid,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [ADDR_W-1:0]  fetch_pc,
    output logic               queue_full,
    input  logic               decode_stall,
    output logic               decode_enable,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam logic [QUEUE_ADDR_W:0] FULL_COUNT = (QUEUE_ADDR_W+1)'(QUEUE_DEPTH);

    logic [QUEUE_ADDR_W-1:0] head_q, head_d;
    logic [QUEUE_ADDR_W-1:0] tail_q, tail_d;
    logic [QUEUE_ADDR_W:0]   count_q, count_d;
    logic                    do_push;
    queue_entry_t            wr_entry;
    queue_entry_t            rd_entry;

    // Full check uses the pre-pop count, so a full queue refuses a push even while popping.
    assign queue_full    = (count_q == FULL_COUNT);
    assign do_push       = rdy && !update_stat && fetch_valid && !queue_full;
    assign decode_enable = rdy && !update_stat && !decode_stall && (count_q != '0);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = fetch_instr;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy == TRUE) begin
            if (update_stat == TRUE) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (do_push) begin
                    tail_d = tail_q + 1'b1;
                end
                if (decode_enable) begin
                    head_d = head_q + 1'b1;
                end
                case ({do_push, decode_enable})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    instr_queue_ram #(
        .DEPTH  (QUEUE_DEPTH),
        .ADDR_W (QUEUE_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (tail_q),
        .wr_data (wr_entry),
        .rd_addr (head_q),
        .rd_data (rd_entry)
    );

    assign instr    = decode_enable ? rd_entry.instr : '0;
    assign instr_pc = decode_enable ? rd_entry.pc    : '0;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue (vector table, directed corners, random vs model)
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        update_stat;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        queue_full;
    logic        decode_stall;
    logic        decode_enable;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t mq[$];

    typedef struct {
        logic        rdy;
        logic        us;
        logic        fv;
        logic        stall;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        exp_full;
        logic        exp_de;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    instr_queue #(
        .QUEUE_DEPTH  (16),
        .QUEUE_ADDR_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .update_stat   (update_stat),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_pc      (fetch_pc),
        .queue_full    (queue_full),
        .decode_stall  (decode_stall),
        .decode_enable (decode_enable),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic u, input logic f, input logic s,
                         input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        rdy          = r;
        update_stat  = u;
        fetch_valid  = f;
        decode_stall = s;
        fetch_instr  = ins;
        fetch_pc     = pc;
        #1;
    endtask

    // Reference: a FIFO of entries; outputs follow directly from its size and front.
    task automatic expect_model(input string tag);
        logic        e_full;
        logic        e_de;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        e_full = (mq.size() == 16);
        e_de   = rdy && !update_stat && !decode_stall && (mq.size() != 0);
        e_ins  = e_de ? mq[0].ins : 32'h0;
        e_pc   = e_de ? mq[0].pc  : 32'h0;
        check({tag, ".full"},  {31'b0, queue_full},    {31'b0, e_full});
        check({tag, ".de"},    {31'b0, decode_enable}, {31'b0, e_de});
        check({tag, ".instr"}, instr,    e_ins);
        check({tag, ".pc"},    instr_pc, e_pc);
    endtask

    task automatic commit();
        bit can_push;
        bit will_pop;
        ent_t e;
        @(posedge clk);
        if (rdy) begin
            if (update_stat) begin
                mq.delete();
            end else begin
                can_push = fetch_valid && (mq.size() < 16);
                will_pop = !decode_stall && (mq.size() != 0);
                if (will_pop) void'(mq.pop_front());
                if (can_push) begin
                    e.pc  = fetch_pc;
                    e.ins = fetch_instr;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic cycle(input string tag, input logic r, input logic u, input logic f, input logic s,
                         input logic [31:0] ins, input logic [31:0] pc);
        drive(r, u, f, s, ins, pc);
        expect_model(tag);
        commit();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst          = 1'b0;
        rdy          = 1'b1;
        update_stat  = 1'b0;
        fetch_valid  = 1'b0;
        decode_stall = 1'b0;
        fetch_instr  = 32'h0;
        fetch_pc     = 32'h0;
        #1;
        check("reset.full", {31'b0, queue_full},    32'h0);
        check("reset.de",   {31'b0, decode_enable}, 32'h0);
        check("reset.instr", instr,    32'h0);
        check("reset.pc",    instr_pc, 32'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic r, input logic u, input logic f, input logic s,
                                input logic [31:0] ins, input logic [31:0] pc,
                                input logic ef, input logic ed,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rdy = r; v.us = u; v.fv = f; v.stall = s; v.ins = ins; v.pc = pc;
        v.exp_full = ef; v.exp_de = ed; v.exp_instr = ei; v.exp_pc = ep;
        return v;
    endfunction

    initial begin
        rst          = 1'b0;
        rdy          = 1'b0;
        update_stat  = 1'b0;
        fetch_valid  = 1'b0;
        decode_stall = 1'b0;
        fetch_instr  = 32'h0;
        fetch_pc     = 32'h0;

        // Vector table: first push, pop, no bypass, rdy freeze, stall, flush.
        vecs.push_back(mk(1, 0, 1, 1, 32'h00500093, 32'h0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0, 0, 1, 32'h00500093, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'hAAAA0001, 32'h4, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 0, 32'hBBBB0002, 32'h8, 0, 1, 32'hAAAA0001, 32'h4));
        vecs.push_back(mk(0, 0, 1, 0, 32'hCCCC0003, 32'hC, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h0,        32'h0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 32'hDDDD0004, 32'h10, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0, 0, 0, 32'h0, 32'h0));

        reset_dut();
        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].us, vecs[i].fv, vecs[i].stall, vecs[i].ins, vecs[i].pc);
            check($sformatf("vec%0d.full", i),  {31'b0, queue_full},    {31'b0, vecs[i].exp_full});
            check($sformatf("vec%0d.de", i),    {31'b0, decode_enable}, {31'b0, vecs[i].exp_de});
            check($sformatf("vec%0d.instr", i), instr,    vecs[i].exp_instr);
            check($sformatf("vec%0d.pc", i),    instr_pc, vecs[i].exp_pc);
            commit();
        end

        // Fill to 16 under stall, refuse a 17th, then drain in order.
        reset_dut();
        for (int i = 0; i < 16; i++) cycle("fill", 1, 0, 1, 1, $urandom, 32'(i * 4));
        drive(1, 0, 1, 1, 32'hDEADBEEF, 32'h40);
        check("full.flag", {31'b0, queue_full}, 32'h1);
        expect_model("full17");
        commit();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 32'h0, 32'h0);
            check("drain.pc", instr_pc, 32'(i * 4));
            expect_model("drain");
            commit();
        end
        cycle("drained", 1, 0, 0, 0, 32'h0, 32'h0);

        // Full queue: pop with offered push in the same cycle drops the push.
        for (int i = 0; i < 16; i++) cycle("fill2", 1, 0, 1, 1, $urandom, 32'h100 + 32'(i * 4));
        cycle("fullpop", 1, 0, 1, 0, 32'h12345678, 32'h999);
        drive(1, 0, 0, 1, 32'h0, 32'h0);
        check("after_fullpop.full", {31'b0, queue_full}, 32'h0);
        commit();
        for (int i = 0; i < 16; i++) cycle("drain2", 1, 0, 0, 0, 32'h0, 32'h0);

        // Flush with a simultaneous fetch.
        for (int i = 0; i < 5; i++) cycle("five", 1, 0, 1, 1, $urandom, 32'h200 + 32'(i * 4));
        cycle("flush", 1, 1, 1, 0, 32'h55555555, 32'h300);
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        check("postflush.de", {31'b0, decode_enable}, 32'h0);
        commit();

        // Continuous push/pop past pointer wrap.
        for (int i = 0; i < 40; i++) cycle("stream", 1, 0, 1, 0, $urandom, 32'h1000 + 32'(i * 4));
        for (int i = 0; i < 2; i++) cycle("stream_tail", 1, 0, 0, 0, 32'h0, 32'h0);

        // Async reset between edges with 3 entries queued.
        for (int i = 0; i < 3; i++) cycle("three", 1, 0, 1, 1, $urandom, 32'h400 + 32'(i * 4));
        drive(1, 0, 0, 0, 32'h0, 32'h0);
        check("pre_rst.de", {31'b0, decode_enable}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_rst.de",    {31'b0, decode_enable}, 32'h0);
        check("async_rst.instr", instr, 32'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        cycle("post_rst", 1, 0, 0, 0, 32'h0, 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) == 0),
                  $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
